ir_fetch: RTL and testbench
===========================

# ir_fetch

LC-3 instruction fetch unit: holds the PC, runs the fetch sequence MAR←PC, PC←PC+1, MDR←M[MAR], IR←MDR against a ready-handshaked memory port, and presents the latched instruction plus its raw immediate fields. It sits directly upstream of the zero/sign-extension stages; offset and immediate fields leave unextended at native width and are widened to 16 bits by the `sext` instances that consume them.

## Interface
- `RESET_PC`, 16'h3000: PC value after reset.
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: request one instruction fetch; sampled only in IDLE.
- `ld_pc` in 1: load `pc_in` into PC; sampled only in IDLE.
- `pc_in` in 16: new PC from PCMUX.
- `mem_ready` in 1: memory read data valid (LC-3 R signal).
- `mem_rdata` in 16: memory read data.
- `mem_req` out 1: memory read request, registered.
- `mem_addr` out 16: MAR contents, registered.
- `pc` out 16: current PC.
- `ir` out 16: instruction register.
- `ir_valid` out 1: one-cycle pulse when `ir` is newly loaded.
- `busy` out 1: high in any state other than IDLE.
- `opcode` out 4: `ir[15:12]`.
- `dr` out 3: `ir[11:9]`.
- `sr1` out 3: `ir[8:6]`.
- `sr2` out 3: `ir[2:0]`.
- `imm5` out 5: `ir[4:0]`.
- `offset6` out 6: `ir[5:0]`.
- `pcoffset9` out 9: `ir[8:0]`.
- `pcoffset11` out 11: `ir[10:0]`.
- `trapvect8` out 8: `ir[7:0]`.

## Operation
- States: IDLE, MEM, LDIR. Reset state is IDLE.
- IDLE:
  - `ld_pc`=1, `start`=0: PC←`pc_in`; stay in IDLE.
  - `start`=1, `ld_pc`=0: MAR←PC, PC←PC+1, `mem_req`←1; go to MEM.
  - `start`=1, `ld_pc`=1: fetch from `pc_in`. MAR←`pc_in`, PC←`pc_in`+1, `mem_req`←1; go to MEM.
- MEM:
  - Hold `mem_req`=1 and `mem_addr` stable.
  - When `mem_ready`=1 on a rising edge: MDR←`mem_rdata`, `mem_req`←0; go to LDIR.
  - Otherwise wait indefinitely; there is no timeout.
- LDIR: IR←MDR, `ir_valid`←1; go to IDLE.
- `ir_valid` is cleared on the next edge. `ir` holds its value until the next LDIR.
- `start` and `ld_pc` are ignored in MEM and LDIR; they are not queued.
- `mem_ready` is ignored outside MEM, including when it is asserted before the request.
- PC increment is modulo 2^16: 16'hFFFF+1 = 16'h0000.
- Field outputs are pure combinational slices of `ir`, with no extension.
- MDR is internal and not exported.

## Timing
- Reset values: `pc`=RESET_PC, `ir`=0, `mem_addr`=0, `mem_req`=0, `ir_valid`=0, `busy`=0, MDR=0. All field outputs are therefore 0.
- Assertion of `rst` in any state forces IDLE and all reset values immediately, without waiting for a clock edge. A fetch in flight is abandoned and `mem_req` drops asynchronously.
- Edge E0 samples `start` in IDLE. From E0, `mem_req`=1, `busy`=1, `mem_addr`=old PC and `pc`=old PC+1.
- Edge E1 is the first edge with `mem_ready`=1 while in MEM.
- At E1+1, `ir` is updated and `ir_valid`=1 for exactly one cycle; `busy` stays 1 through this edge.
- At E1+2, `ir_valid`=0 and `busy`=0.
- Minimum latency from the `start` edge to `ir` valid is 2 edges (`mem_ready` held high), and each wait cycle adds one edge.
- Minimum issue interval is 3 cycles per fetch, with `start` held high continuously.
- A new `start` is honored on the same edge on which `busy` returns to 0.

## Test plan
- Reset then idle: `pc`=16'h3000, `mem_req`=0, `ir`=0.
- Fetch with no wait: assert `start`, tie `mem_ready`=1, memory returns 16'h1261 at 16'h3000.
  - `mem_addr`=16'h3000 and `pc`=16'h3001 after E0.
  - `ir`=16'h1261 two edges after E0, with a single `ir_valid` pulse.
  - `opcode`=1, `dr`=1, `sr1`=1, `imm5`=5'h01.
- Wait states: `mem_ready` low for 4 cycles, then high.
  - `mem_req` and `mem_addr` stay stable for all 5 MEM cycles.
  - `ir` loads 6 edges after E0.
- PC load and priority:
  - `ld_pc`=1 with `pc_in`=16'h4000 in IDLE gives `pc`=16'h4000.
  - `start` and `ld_pc` together with `pc_in`=16'h5000 give `mem_addr`=16'h5000 and `pc`=16'h5001.
  - `ld_pc` asserted during MEM leaves `pc` unchanged.
- Wrap: `ld_pc` with `pc_in`=16'hFFFF, then `start`. Result: `mem_addr`=16'hFFFF, `pc`=16'h0000.
- Reset mid-fetch: pulse `rst` in MEM, asynchronously between edges.
  - `mem_req`=0 and `pc`=16'h3000 before the next edge.
  - No `ir_valid` pulse follows.
  - A later `start` fetches normally.

Source files
------------

// File: rtl/ir_fetch.sv
// LC-3 instruction fetch unit: PC, MAR, MDR and IR around a ready-handshaked
// memory read, plus raw (unextended) instruction field slices.
module ir_fetch #(
  parameter logic [15:0] RESET_PC = 16'h3000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        ld_pc,
  input  logic [15:0] pc_in,
  input  logic        mem_ready,
  input  logic [15:0] mem_rdata,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  output logic [15:0] pc,
  output logic [15:0] ir,
  output logic        ir_valid,
  output logic        busy,
  output logic [3:0]  opcode,
  output logic [2:0]  dr,
  output logic [2:0]  sr1,
  output logic [2:0]  sr2,
  output logic [4:0]  imm5,
  output logic [5:0]  offset6,
  output logic [8:0]  pcoffset9,
  output logic [10:0] pcoffset11,
  output logic [7:0]  trapvect8
);

  typedef enum logic [1:0] {IDLE, MEM, LDIR} state_t;

  state_t      state, state_nx;
  logic [15:0] mdr, mdr_nx;
  logic [15:0] pc_nx, mar_nx, ir_nx;
  logic        req_nx, irv_nx;
  logic [15:0] fetch_pc;

  // A simultaneous ld_pc redirects the fetch itself, not just the next one.
  assign fetch_pc = ld_pc ? pc_in : pc;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a variable unassigned, which would infer a latch.
    state_nx = state;
    pc_nx    = pc;
    mar_nx   = mem_addr;
    mdr_nx   = mdr;
    ir_nx    = ir;
    req_nx   = mem_req;
    irv_nx   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          mar_nx   = fetch_pc;
          pc_nx    = fetch_pc + 16'd1;
          req_nx   = 1'b1;
          state_nx = MEM;
        end else if (ld_pc) begin
          pc_nx = pc_in;
        end
      end
      MEM: begin
        if (mem_ready) begin
          mdr_nx   = mem_rdata;
          req_nx   = 1'b0;
          state_nx = LDIR;
        end
      end
      LDIR: begin
        ir_nx    = mdr;
        irv_nx   = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      mem_addr <= 16'h0000;
      mem_req  <= 1'b0;
      mdr      <= 16'h0000;
      ir       <= 16'h0000;
      ir_valid <= 1'b0;
    end else begin
      state    <= state_nx;
      pc       <= pc_nx;
      mem_addr <= mar_nx;
      mem_req  <= req_nx;
      mdr      <= mdr_nx;
      ir       <= ir_nx;
      ir_valid <= irv_nx;
    end
  end

  // busy covers the ir_valid cycle too, so it falls on the edge where the
  // FSM can already accept the next start.
  assign busy = (state != IDLE) | ir_valid;

  assign opcode     = ir[15:12];
  assign dr         = ir[11:9];
  assign sr1        = ir[8:6];
  assign sr2        = ir[2:0];
  assign imm5       = ir[4:0];
  assign offset6    = ir[5:0];
  assign pcoffset9  = ir[8:0];
  assign pcoffset11 = ir[10:0];
  assign trapvect8  = ir[7:0];

endmodule

// File: tb/tb_ir_fetch.sv
// Directed bench for ir_fetch: stimulus pushes expected instructions into a
// scoreboard queue, a negedge monitor pops and compares on each ir_valid.
module tb_ir_fetch;

  logic        clk = 1'b0;
  logic        rst, start, ld_pc, mem_ready, mem_req, ir_valid, busy;
  logic [15:0] pc_in, mem_rdata, mem_addr, pc, ir;
  logic [3:0]  opcode;
  logic [2:0]  dr, sr1, sr2;
  logic [4:0]  imm5;
  logic [5:0]  offset6;
  logic [8:0]  pcoffset9;
  logic [10:0] pcoffset11;
  logic [7:0]  trapvect8;

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];

  ir_fetch #(.RESET_PC(16'h3000)) dut (
    .clk(clk), .rst(rst), .start(start), .ld_pc(ld_pc), .pc_in(pc_in),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_req(mem_req),
    .mem_addr(mem_addr), .pc(pc), .ir(ir), .ir_valid(ir_valid), .busy(busy),
    .opcode(opcode), .dr(dr), .sr1(sr1), .sr2(sr2), .imm5(imm5),
    .offset6(offset6), .pcoffset9(pcoffset9), .pcoffset11(pcoffset11),
    .trapvect8(trapvect8)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every ir_valid pulse must match a queued expectation.
  always @(negedge clk) begin
    if (!rst && ir_valid) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb_unexpected_ir_valid: got ir %h expected no pulse", ir);
      end else begin
        check("sb_ir", ir, exp_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; ld_pc = 1'b0; pc_in = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    #12 rst = 1'b0;
    step();
    check("rst_pc", pc, 16'h3000);
    check("rst_mem_req", 16'(mem_req), 16'h0);
    check("rst_ir", ir, 16'h0000);
    check("rst_busy", 16'(busy), 16'h0);
    check("rst_mem_addr", mem_addr, 16'h0000);

    // Fetch with no wait states.
    start = 1'b1; mem_ready = 1'b1; mem_rdata = 16'h1261;
    exp_q.push_back(16'h1261);
    step();
    start = 1'b0;
    check("nw_mem_addr", mem_addr, 16'h3000);
    check("nw_pc", pc, 16'h3001);
    check("nw_mem_req", 16'(mem_req), 16'h1);
    check("nw_busy", 16'(busy), 16'h1);
    step();
    check("nw_req_drop", 16'(mem_req), 16'h0);
    check("nw_no_early_valid", 16'(ir_valid), 16'h0);
    step();
    check("nw_ir", ir, 16'h1261);
    check("nw_ir_valid", 16'(ir_valid), 16'h1);
    check("nw_busy_ldir", 16'(busy), 16'h1);
    check("nw_opcode", 16'(opcode), 16'h1);
    check("nw_dr", 16'(dr), 16'h1);
    check("nw_sr1", 16'(sr1), 16'h1);
    check("nw_imm5", 16'(imm5), 16'h01);
    step();
    check("nw_valid_one_cycle", 16'(ir_valid), 16'h0);
    check("nw_busy_idle", 16'(busy), 16'h0);
    check("nw_ir_hold", ir, 16'h1261);

    // Four wait states.
    start = 1'b1; mem_ready = 1'b0; mem_rdata = 16'h5A3C;
    exp_q.push_back(16'h5A3C);
    step();
    start = 1'b0;
    check("ws_pc", pc, 16'h3002);
    for (int i = 0; i < 5; i++) begin
      check("ws_mem_req", 16'(mem_req), 16'h1);
      check("ws_mem_addr", mem_addr, 16'h3001);
      check("ws_ir_valid", 16'(ir_valid), 16'h0);
      if (i < 4) step();
    end
    mem_ready = 1'b1;
    step();
    check("ws_req_drop", 16'(mem_req), 16'h0);
    mem_ready = 1'b0;
    step();
    check("ws_ir", ir, 16'h5A3C);
    step();

    // PC load, then start+ld_pc, then ld_pc ignored in MEM.
    ld_pc = 1'b1; pc_in = 16'h4000;
    step();
    ld_pc = 1'b0;
    check("ld_pc", pc, 16'h4000);
    check("ld_no_req", 16'(mem_req), 16'h0);
    start = 1'b1; ld_pc = 1'b1; pc_in = 16'h5000; mem_rdata = 16'hF025;
    exp_q.push_back(16'hF025);
    step();
    start = 1'b0; pc_in = 16'h1234;
    check("sl_mem_addr", mem_addr, 16'h5000);
    check("sl_pc", pc, 16'h5001);
    step();
    check("mem_ld_ignored", pc, 16'h5001);
    ld_pc = 1'b0; mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    step();
    check("trap_opcode", 16'(opcode), 16'hF);
    check("trapvect8", 16'(trapvect8), 16'h25);
    step();

    // PC wrap.
    ld_pc = 1'b1; pc_in = 16'hFFFF;
    step();
    ld_pc = 1'b0; start = 1'b1; mem_ready = 1'b1; mem_rdata = 16'h6A7F;
    exp_q.push_back(16'h6A7F);
    step();
    start = 1'b0;
    check("wrap_mem_addr", mem_addr, 16'hFFFF);
    check("wrap_pc", pc, 16'h0000);
    step();
    step();
    check("ldr_dr", 16'(dr), 16'h5);
    check("ldr_offset6", 16'(offset6), 16'h3F);
    step();

    // Back-to-back fetches with start held: 3-cycle issue interval.
    start = 1'b1; mem_rdata = 16'h0E05;
    exp_q.push_back(16'h0E05);
    exp_q.push_back(16'h0E05);
    step();
    check("b2b_addr0", mem_addr, 16'h0000);
    check("b2b_pc0", pc, 16'h0001);
    step();
    step();
    check("br_pcoffset9", 16'(pcoffset9), 16'h005);
    check("br_pcoffset11", 16'(pcoffset11), 16'h605);
    step();
    start = 1'b0;
    check("b2b_addr1", mem_addr, 16'h0001);
    check("b2b_pc1", pc, 16'h0002);
    check("b2b_req1", 16'(mem_req), 16'h1);
    step();
    step();
    step();

    // Asynchronous reset in MEM abandons the fetch.
    start = 1'b1; mem_ready = 1'b0;
    step();
    start = 1'b0;
    check("ar_req_before", 16'(mem_req), 16'h1);
    #2 rst = 1'b1;
    #1;
    check("ar_req_async", 16'(mem_req), 16'h0);
    check("ar_pc_async", pc, 16'h3000);
    check("ar_busy_async", 16'(busy), 16'h0);
    #1 rst = 1'b0;
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("ar_no_valid", 16'(ir_valid), 16'h0);
    end
    start = 1'b1; mem_rdata = 16'h1261;
    exp_q.push_back(16'h1261);
    step();
    start = 1'b0;
    check("ar_refetch_addr", mem_addr, 16'h3000);
    check("ar_refetch_pc", pc, 16'h3001);
    step();
    step();
    check("ar_refetch_ir", ir, 16'h1261);
    step();
    step();

    check("sb_drained", 16'(exp_q.size()), 16'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
